receive_all: RTL and testbench

//  Receiving end of the inter-board 4-phase Request/Ack link driven by the peer's send_all.

---
 rtl/receive_all_pkg.sv | 42 ++++
 rtl/receive_all_single.sv | 65 ++++++
 rtl/receive_all.sv | 130 +++++++++++++
 tb/tb_receive_all.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/receive_all_pkg.sv
// Shared constants for the inter-board Request/Ack link (also used by send_all).
package receive_all_pkg;

    localparam int WORD_W     = 6;
    localparam int MSG_TYPE_W = 4;
    localparam int BLOCK_X_W  = 5;
    localparam int BLOCK_Y_W  = 3;
    localparam int CARD_W     = 6;
    localparam int SEL_LEN_W  = 3;
    localparam int MOVE_DIR_W = 1;

    // Peer's global reset request; never a legal msg_type.
    localparam logic [WORD_W-1:0] RST_WORD = 6'h3F;

    // Message FSM: one step per received word.
    typedef enum logic [2:0] {
        STEP_1 = 3'd0,
        STEP_2 = 3'd1,
        STEP_3 = 3'd2,
        STEP_4 = 3'd3,
        STEP_5 = 3'd4,
        STEP_6 = 3'd5
    } step_e;

    // Word FSM: one 4-phase handshake per word.
    typedef enum logic [1:0] {
        WAIT_IDLE     = 2'd0,
        WAIT_REQ_UP   = 2'd1,
        WAIT_REQ_DOWN = 2'd2
    } word_state_e;

    // All fields of one message, each already truncated to its width.
    typedef struct packed {
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [BLOCK_X_W-1:0]  block_x;
        logic [BLOCK_Y_W-1:0]  block_y;
        logic [CARD_W-1:0]     card;
        logic [SEL_LEN_W-1:0]  sel_len;
        logic [MOVE_DIR_W-1:0] move_dir;
    } msg_fields_t;

endpackage

// File: rtl/receive_all_single.sv
// Single-word receiver: Request synchronizer, 4-phase word FSM, Ack and data latch.
module receive_single
    import receive_all_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Request_in,
    input  logic [WORD_W-1:0] inter_data_in,
    output logic              Ack_out,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    word_state_e            state_q, state_d;
    logic                   capture;

    // Request synchronizer chain.
    // NOTE: the synchronizer is deliberately not reset, so a Request held high across rst
    // still reads as high afterwards and WAIT_IDLE can refuse it as a new word.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], Request_in};
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Word FSM next-state: capture on the synchronized rising Request.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            WAIT_IDLE:     if (!req_s) state_d = WAIT_REQ_UP;
            WAIT_REQ_UP:   if (req_s) begin
                               state_d = WAIT_REQ_DOWN;
                               capture = 1'b1;
                           end
            WAIT_REQ_DOWN: if (!req_s) state_d = WAIT_REQ_UP;
            default:       state_d = WAIT_IDLE;
        endcase
    end

    // State, data latch, word_valid pulse and registered Ack.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_IDLE;
            word_valid <= 1'b0;
            word       <= '0;
            Ack_out    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_valid <= capture;
            if (capture) word <= inter_data_in;
            // Ack rises one edge after the latch and falls on the edge that leaves WAIT_REQ_DOWN.
            Ack_out    <= (state_q == WAIT_REQ_DOWN) && (state_d == WAIT_REQ_DOWN);
        end
    end

endmodule

// File: rtl/receive_all.sv
// Message receiver: assembles six words into one registered message for GameControl,
// detects the peer reset word and discards stalled partial messages.
module receive_all
    import receive_all_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Request_in,
    input  logic [5:0] inter_data_in,
    output logic       Ack_out,
    output logic       interboard_rst,
    output logic       inter_ready,
    output logic [3:0] inter_msg_type,
    output logic [4:0] inter_block_x,
    output logic [2:0] inter_block_y,
    output logic [5:0] inter_card,
    output logic [2:0] inter_sel_len,
    output logic [0:0] inter_move_dir
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic              word_valid;
    logic [WORD_W-1:0] word;

    step_e             step_q, step_d;
    msg_fields_t       part_q, part_d;   // words collected so far
    msg_fields_t       out_q, out_d;     // last completed message
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_d, irst_d;

    receive_single #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_single (
        .clk           (clk),
        .rst           (rst),
        .Request_in    (Request_in),
        .inter_data_in (inter_data_in),
        .Ack_out       (Ack_out),
        .word_valid    (word_valid),
        .word          (word)
    );

    // Message FSM next-state, field loading, pulses and idle timeout.
    always_comb begin
        step_d  = step_q;
        part_d  = part_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        irst_d  = 1'b0;
        if (word_valid) begin
            // A word arriving on the timeout cycle wins.
            cnt_d = '0;
            case (step_q)
                STEP_1: begin
                    if (word == RST_WORD) begin
                        irst_d = 1'b1;
                        out_d  = '0;
                    end else begin
                        part_d.msg_type = word[MSG_TYPE_W-1:0];
                        step_d          = STEP_2;
                    end
                end
                STEP_2: begin
                    part_d.block_x = word[BLOCK_X_W-1:0];
                    step_d         = STEP_3;
                end
                STEP_3: begin
                    part_d.block_y = word[BLOCK_Y_W-1:0];
                    step_d         = STEP_4;
                end
                STEP_4: begin
                    part_d.card = word[CARD_W-1:0];
                    step_d      = STEP_5;
                end
                STEP_5: begin
                    part_d.sel_len = word[SEL_LEN_W-1:0];
                    step_d         = STEP_6;
                end
                STEP_6: begin
                    out_d          = part_q;
                    out_d.move_dir = word[MOVE_DIR_W-1:0];
                    ready_d        = 1'b1;
                    step_d         = STEP_1;
                end
                default: step_d = STEP_1;
            endcase
        end else if (step_q != STEP_1) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                step_d = STEP_1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Message state, field and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q         <= STEP_1;
            part_q         <= '0;
            out_q          <= '0;
            cnt_q          <= '0;
            inter_ready    <= 1'b0;
            interboard_rst <= 1'b0;
        end else begin
            step_q         <= step_d;
            part_q         <= part_d;
            out_q          <= out_d;
            cnt_q          <= cnt_d;
            inter_ready    <= ready_d;
            interboard_rst <= irst_d;
        end
    end

    assign inter_msg_type = out_q.msg_type;
    assign inter_block_x  = out_q.block_x;
    assign inter_block_y  = out_q.block_y;
    assign inter_card     = out_q.card;
    assign inter_sel_len  = out_q.sel_len;
    assign inter_move_dir = out_q.move_dir;

endmodule

// File: tb/tb_receive_all.sv
// Bench for receive_all: models the peer sender on its own timing, scoreboards messages.
module tb_receive_all;

    logic       clk = 1'b0;
    logic       rst;
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out;
    logic       interboard_rst;
    logic       inter_ready;
    logic [3:0] inter_msg_type;
    logic [4:0] inter_block_x;
    logic [2:0] inter_block_y;
    logic [5:0] inter_card;
    logic [2:0] inter_sel_len;
    logic [0:0] inter_move_dir;

    typedef struct packed {
        logic       is_rst;
        logic [3:0] mt;
        logic [4:0] bx;
        logic [2:0] by;
        logic [5:0] cd;
        logic [2:0] sl;
        logic       md;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passes = 0;
    int   ack_cnt   = 0;
    int   ready_cnt = 0;
    int   irst_cnt  = 0;

    receive_all #(
        .SYNC_STAGES (2),
        .TIMEOUT     (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Request_in     (Request_in),
        .inter_data_in  (inter_data_in),
        .Ack_out        (Ack_out),
        .interboard_rst (interboard_rst),
        .inter_ready    (inter_ready),
        .inter_msg_type (inter_msg_type),
        .inter_block_x  (inter_block_x),
        .inter_block_y  (inter_block_y),
        .inter_card     (inter_card),
        .inter_sel_len  (inter_sel_len),
        .inter_move_dir (inter_move_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Peer's view of a message: each field keeps only its low bits.
    task automatic push_msg(input logic [5:0] a, b, c, d, e, f);
        exp_t x;
        x.is_rst = 1'b0;
        x.mt = a[3:0]; x.bx = b[4:0]; x.by = c[2:0];
        x.cd = d;      x.sl = e[2:0]; x.md = f[0];
        exp_q.push_back(x);
    endtask

    task automatic push_rst();
        exp_q.push_back('{is_rst: 1'b1, default: '0});
    endtask

    // One 4-phase handshake, sender stepping on a 7 ns grid unrelated to clk.
    task automatic send_word(input logic [5:0] w, input int hold_cycles);
        int n;
        #3 inter_data_in = w;
        #4 Request_in = 1'b1;
        n = 0;
        while (Ack_out !== 1'b1 && n < 300) begin #7; n++; end
        check("ack_rise", Ack_out, 1);
        repeat (hold_cycles) @(posedge clk);
        #3 Request_in = 1'b0;
        n = 0;
        while (Ack_out !== 1'b0 && n < 300) begin #7; n++; end
        check("ack_fall", Ack_out, 0);
    endtask

    task automatic send_msg(input logic [5:0] a, b, c, d, e, f, input int hold);
        send_word(a, hold); send_word(b, hold); send_word(c, hold);
        send_word(d, hold); send_word(e, hold); send_word(f, hold);
    endtask

    // Count Ack handshakes.
    always @(posedge Ack_out) ack_cnt++;

    // Scoreboard: compare every output pulse against the oldest expectation.
    always @(negedge clk) begin
        if (inter_ready === 1'b1 || interboard_rst === 1'b1) begin
            exp_t e;
            check("pulse_exclusive", {31'd0, inter_ready & interboard_rst}, 0);
            if (inter_ready === 1'b1) ready_cnt++;
            if (interboard_rst === 1'b1) irst_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {31'd0, inter_ready}, {31'd0, interboard_rst});
                check("unexpected_pulse_any", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, interboard_rst}, {31'd0, e.is_rst});
                check("msg_type", inter_msg_type, e.mt);
                check("block_x",  inter_block_x,  e.bx);
                check("block_y",  inter_block_y,  e.by);
                check("card",     inter_card,     e.cd);
                check("sel_len",  inter_sel_len,  e.sl);
                check("move_dir", inter_move_dir, e.md);
            end
        end
    end

    initial begin
        int a0;
        int highs;
        rst = 1'b1;
        Request_in = 1'b0;
        inter_data_in = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {Ack_out, interboard_rst, inter_ready, inter_msg_type, inter_block_x,
                                inter_block_y, inter_card, inter_sel_len, inter_move_dir}, 0);

        // Basic message; six handshakes.
        a0 = ack_cnt;
        push_msg(6, 17, 5, 42, 3, 1);
        send_msg(6, 17, 5, 42, 3, 1, 0);
        repeat (5) @(negedge clk);
        check("t1_ack_count", ack_cnt - a0, 6);

        // Peer reset word, then a normal message.
        push_rst();
        send_word(6'h3F, 0);
        repeat (5) @(negedge clk);
        check("t2_irst_count", irst_cnt, 1);
        push_msg(2, 9, 7, 11, 4, 0);
        send_msg(2, 9, 7, 11, 4, 0, 0);

        // 6'h3F as card is ordinary data.
        push_msg(3, 1, 2, 6'h3F, 6, 1);
        send_msg(3, 1, 2, 6'h3F, 6, 1, 0);
        repeat (5) @(negedge clk);
        check("t3_irst_count", irst_cnt, 1);

        // Stalled partial message is discarded by the timeout.
        send_word(9, 0); send_word(10, 0); send_word(11, 0);
        repeat (70) @(posedge clk);
        push_msg(1, 2, 3, 4, 5, 0);
        send_msg(1, 2, 3, 4, 5, 0, 0);
        repeat (5) @(negedge clk);
        check("t4_ready_count", ready_cnt, 4);

        // Request held high across rst.
        #3 inter_data_in = 6'h02;
        #4 Request_in = 1'b1;
        a0 = 0;
        while (Ack_out !== 1'b1 && a0 < 300) begin #7; a0++; end
        check("t5_ack_before_rst", Ack_out, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("t5_ack_drop_in_rst", Ack_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Ack_out !== 1'b0) highs++;
        end
        check("t5_ack_held_low", highs, 0);
        check("t5_fields_cleared", {inter_msg_type, inter_block_x, inter_block_y,
                                    inter_card, inter_sel_len, inter_move_dir}, 0);
        #3 Request_in = 1'b0;
        repeat (5) @(negedge clk);
        push_msg(7, 8, 1, 9, 2, 1);
        send_msg(7, 8, 1, 9, 2, 1, 0);

        // Upper bits of each word are dropped.
        exp_q.push_back('{is_rst: 1'b0, mt: 4'b0101, bx: 5'd30, by: 3'd1, cd: 6'd33, sl: 3'd7, md: 1'b0});
        send_msg(6'b11_0101, 6'b11_1110, 6'b00_1001, 6'd33, 6'b10_1111, 6'b11_1110, 0);

        // Slow sender: Request held 50 cycles after each Ack.
        a0 = ack_cnt;
        push_msg(4, 20, 6, 50, 1, 1);
        send_msg(4, 20, 6, 50, 1, 1, 50);
        repeat (5) @(negedge clk);
        check("t7_ack_count", ack_cnt - a0, 6);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("ready_total", ready_cnt, 7);
        check("irst_total", irst_cnt, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Absolute time bound in case a wait never resolves.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, observed %0d/%0d", passes, total);
        $fatal(1, "timeout");
    end

endmodule
